// File: rtl/wide_adder_seq_pkg.sv
// Shared types and helpers for the chunk-serial wide adder.
package wide_adder_seq_pkg;

  typedef enum logic [1:0] {IDLE, ADD, DONE} state_t;

  // Chunk index width; a single-chunk build still needs a 1-bit index.
  function automatic int unsigned idx_width(input int unsigned words);
    return (words > 1) ? $clog2(words) : 1;
  endfunction

endpackage

// File: rtl/wide_adder_seq_if.sv
// Operand/result handshake bundle for wide_adder_seq.
// The ovf signal exists only when WIDE_ADDER_SEQ_OVF_EN is defined.
interface wide_adder_seq_if #(
  parameter int unsigned N     = 8,
  parameter int unsigned WORDS = 4
);
  localparam int unsigned W = N * WORDS;

  logic         in_valid;
  logic         in_ready;
  logic [W-1:0] a;
  logic [W-1:0] b;
  logic         cin;
  logic         out_valid;
  logic         out_ready;
  logic [W-1:0] sum;
  logic         cout;
  logic         busy;
`ifdef WIDE_ADDER_SEQ_OVF_EN
  logic         ovf;

  modport master (
    output in_valid, a, b, cin, out_ready,
    input  in_ready, out_valid, sum, cout, busy, ovf
  );
  modport slave (
    input  in_valid, a, b, cin, out_ready,
    output in_ready, out_valid, sum, cout, busy, ovf
  );
`else
  modport master (
    output in_valid, a, b, cin, out_ready,
    input  in_ready, out_valid, sum, cout, busy
  );
  modport slave (
    input  in_valid, a, b, cin, out_ready,
    output in_ready, out_valid, sum, cout, busy
  );
`endif

endinterface

// File: rtl/fa.sv
// N-bit combinational adder with carry in/out; the chunk datapath of wide_adder_seq.
module fa #(
  parameter int unsigned N = 8
) (
  input  logic [N-1:0] a,
  input  logic [N-1:0] b,
  input  logic         cin,
  output logic [N-1:0] sum,
  output logic         cout
);

  logic [N:0] full;

  assign full = {1'b0, a} + {1'b0, b} + {{N{1'b0}}, cin};
  assign sum  = full[N-1:0];
  assign cout = full[N];

endmodule

// File: rtl/wide_adder_seq.sv
// Multi-cycle W = N*WORDS adder: one N-bit chunk per cycle through a single fa, carry fed back.
// Optional signed-overflow output enabled by defining WIDE_ADDER_SEQ_OVF_EN.
module wide_adder_seq
  import wide_adder_seq_pkg::*;
#(
  parameter int unsigned N     = 8,
  parameter int unsigned WORDS = 4
) (
  input logic             clk,
  input logic             rst_n,
  wide_adder_seq_if.slave bus
);

  localparam int unsigned W  = N * WORDS;
  localparam int unsigned IW = idx_width(WORDS);
  localparam logic [IW-1:0] LastIdx = IW'(WORDS - 1);

  state_t state_q, state_d;

  logic [W-1:0]  a_q, b_q, sum_q;
  logic          carry_q, cout_q;
  logic [IW-1:0] idx_q;

  logic [N-1:0] fa_a, fa_b, fa_sum;
  logic         fa_cout;
  logic         accept, last;

  assign fa_a   = a_q[idx_q*N +: N];
  assign fa_b   = b_q[idx_q*N +: N];
  assign accept = (state_q == IDLE) && bus.in_valid;
  assign last   = (idx_q == LastIdx);

  fa #(.N(N)) u_fa (
    .a    (fa_a),
    .b    (fa_b),
    .cin  (carry_q),
    .sum  (fa_sum),
    .cout (fa_cout)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d       = state_q;
    bus.in_ready  = 1'b0;
    bus.out_valid = 1'b0;
    bus.busy      = 1'b0;
    unique case (state_q)
      IDLE: begin
        bus.in_ready = 1'b1;
        if (bus.in_valid) state_d = ADD;
      end
      ADD: begin
        bus.busy = 1'b1;
        if (last) state_d = DONE;
      end
      DONE: begin
        bus.busy      = 1'b1;
        bus.out_valid = 1'b1;
        if (bus.out_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_q     <= '0;
      b_q     <= '0;
      sum_q   <= '0;
      carry_q <= 1'b0;
      cout_q  <= 1'b0;
      idx_q   <= '0;
    end else if (accept) begin
      a_q     <= bus.a;
      b_q     <= bus.b;
      carry_q <= bus.cin;
      idx_q   <= '0;
    end else if (state_q == ADD) begin
      sum_q[idx_q*N +: N] <= fa_sum;
      carry_q             <= fa_cout;
      if (last) begin
        cout_q <= fa_cout;
      end else begin
        idx_q <= idx_q + IW'(1);
      end
    end
  end

  assign bus.sum  = sum_q;
  assign bus.cout = cout_q;

`ifdef WIDE_ADDER_SEQ_OVF_EN
  logic ovf_q;
  logic msb_cin;

  // Carry into the MSB recovered from the top chunk's MSB operand and sum bits.
  assign msb_cin = fa_a[N-1] ^ fa_b[N-1] ^ fa_sum[N-1];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ovf_q <= 1'b0;
    end else if ((state_q == ADD) && last) begin
      ovf_q <= msb_cin ^ fa_cout;
    end
  end

  assign bus.ovf = ovf_q;
`endif

endmodule

// File: tb/tb_wide_adder_seq.sv
// Self-checking bench for wide_adder_seq: a WORDS=4 and a WORDS=1 instance against an arithmetic model.
module tb_wide_adder_seq;

  logic clk = 1'b0;
  logic rst_n;
  int   n_tests = 0;
  int   n_fail  = 0;

  always #5 clk = ~clk;

  wide_adder_seq_if #(.N(8), .WORDS(4)) if4 ();
  wide_adder_seq_if #(.N(8), .WORDS(1)) if1 ();

  wide_adder_seq #(.N(8), .WORDS(4)) dut4 (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (if4.slave)
  );

  wide_adder_seq #(.N(8), .WORDS(1)) dut1 (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (if1.slave)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Full-precision reference: {cout, sum} and signed overflow of a+b+cin.
  function automatic logic [32:0] ref4(input logic [31:0] a, b, input logic c);
    return {1'b0, a} + {1'b0, b} + 33'(c);
  endfunction

  function automatic logic ovf_ref(input logic a_msb, b_msb, s_msb);
    return (a_msb == b_msb) && (s_msb != a_msb);
  endfunction

  task automatic run4(input logic [31:0] a, b, input logic c, input int stall);
    logic [32:0] e;
    int          cyc;
    e = ref4(a, b, c);
    @(negedge clk);
    chk("w4 in_ready idle", 64'(if4.in_ready), 64'd1);
    if4.a = a; if4.b = b; if4.cin = c; if4.in_valid = 1'b1; if4.out_ready = 1'b0;
    @(negedge clk);
    if4.in_valid = 1'b0; if4.a = $urandom; if4.b = $urandom; if4.cin = ~c;
    chk("w4 busy in add", 64'(if4.busy), 64'd1);
    chk("w4 in_ready add", 64'(if4.in_ready), 64'd0);
    cyc = 0;
    while (!if4.out_valid && cyc < 20) begin
      @(negedge clk);
      cyc++;
    end
    chk("w4 latency", 64'(cyc), 64'd4);
    chk("w4 sum", 64'(if4.sum), 64'(e[31:0]));
    chk("w4 cout", 64'(if4.cout), 64'(e[32]));
`ifdef WIDE_ADDER_SEQ_OVF_EN
    chk("w4 ovf", 64'(if4.ovf), 64'(ovf_ref(a[31], b[31], e[31])));
`endif
    for (int i = 0; i < stall; i++) begin
      @(negedge clk);
      chk("w4 stall valid", 64'(if4.out_valid), 64'd1);
      chk("w4 stall sum", 64'(if4.sum), 64'(e[31:0]));
      chk("w4 stall cout", 64'(if4.cout), 64'(e[32]));
      chk("w4 stall in_ready", 64'(if4.in_ready), 64'd0);
    end
    if4.out_ready = 1'b1;
    @(negedge clk);
    if4.out_ready = 1'b0;
    chk("w4 valid drop", 64'(if4.out_valid), 64'd0);
    chk("w4 in_ready back", 64'(if4.in_ready), 64'd1);
  endtask

  task automatic run1(input logic [7:0] a, b, input logic c);
    logic [8:0] e;
    int         cyc;
    e = {1'b0, a} + {1'b0, b} + 9'(c);
    @(negedge clk);
    if1.a = a; if1.b = b; if1.cin = c; if1.in_valid = 1'b1; if1.out_ready = 1'b0;
    @(negedge clk);
    if1.in_valid = 1'b0;
    cyc = 0;
    while (!if1.out_valid && cyc < 10) begin
      @(negedge clk);
      cyc++;
    end
    chk("w1 latency", 64'(cyc), 64'd1);
    chk("w1 sum", 64'(if1.sum), 64'(e[7:0]));
    chk("w1 cout", 64'(if1.cout), 64'(e[8]));
`ifdef WIDE_ADDER_SEQ_OVF_EN
    chk("w1 ovf", 64'(if1.ovf), 64'(ovf_ref(a[7], b[7], e[7])));
`endif
    if1.out_ready = 1'b1;
    @(negedge clk);
    if1.out_ready = 1'b0;
    chk("w1 in_ready back", 64'(if1.in_ready), 64'd1);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [32:0] e;
    int          cyc;

    rst_n = 1'b0;
    if4.in_valid = 1'b0; if4.a = '0; if4.b = '0; if4.cin = 1'b0; if4.out_ready = 1'b0;
    if1.in_valid = 1'b0; if1.a = '0; if1.b = '0; if1.cin = 1'b0; if1.out_ready = 1'b0;
    #12;
    chk("rst in_ready", 64'(if4.in_ready), 64'd1);
    chk("rst out_valid", 64'(if4.out_valid), 64'd0);
    chk("rst busy", 64'(if4.busy), 64'd0);
    chk("rst sum", 64'(if4.sum), 64'd0);
    chk("rst cout", 64'(if4.cout), 64'd0);
    chk("rst w1 in_ready", 64'(if1.in_ready), 64'd1);
`ifdef WIDE_ADDER_SEQ_OVF_EN
    chk("rst ovf", 64'(if4.ovf), 64'd0);
`endif
    @(negedge clk);
    rst_n = 1'b1;

    // out_ready while idle has no effect
    if4.out_ready = 1'b1;
    @(negedge clk);
    chk("idle out_ready ignored", 64'(if4.out_valid), 64'd0);
    chk("idle stays ready", 64'(if4.in_ready), 64'd1);
    if4.out_ready = 1'b0;

    run4(32'hFFFF_FFFF, 32'h0000_0001, 1'b0, 0);
    run4(32'h1234_5678, 32'h1111_1111, 1'b1, 5);

    // Reset two ADD cycles into a transaction: result discarded, no out_valid pulse.
    @(negedge clk);
    if4.a = 32'h0000_00FF; if4.b = 32'h0000_0001; if4.cin = 1'b0; if4.in_valid = 1'b1;
    @(negedge clk);
    if4.in_valid = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b0;
    #1;
    chk("midrst in_ready", 64'(if4.in_ready), 64'd1);
    chk("midrst busy", 64'(if4.busy), 64'd0);
    chk("midrst out_valid", 64'(if4.out_valid), 64'd0);
    chk("midrst sum", 64'(if4.sum), 64'd0);
    chk("midrst cout", 64'(if4.cout), 64'd0);
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      if (i == 1) rst_n = 1'b1;
      chk("midrst no pulse", 64'(if4.out_valid), 64'd0);
    end
    run4(32'd2, 32'd3, 1'b0, 0);

    // in_valid held through ADD/DONE with new operands; second set taken only from IDLE.
    @(negedge clk);
    if4.a = 32'hDEAD_BEEF; if4.b = 32'h0101_0101; if4.cin = 1'b0;
    if4.in_valid = 1'b1; if4.out_ready = 1'b1;
    @(negedge clk);
    if4.a = 32'h8000_0001; if4.b = 32'h8000_0002; if4.cin = 1'b1;
    cyc = 0;
    while (!if4.out_valid && cyc < 20) begin
      chk("hold in_ready low", 64'(if4.in_ready), 64'd0);
      @(negedge clk);
      cyc++;
    end
    e = ref4(32'hDEAD_BEEF, 32'h0101_0101, 1'b0);
    chk("hold first latency", 64'(cyc), 64'd4);
    chk("hold first sum", 64'(if4.sum), 64'(e[31:0]));
    chk("hold done in_ready", 64'(if4.in_ready), 64'd0);
    @(negedge clk);
    chk("hold idle ready", 64'(if4.in_ready), 64'd1);
    chk("hold idle valid", 64'(if4.out_valid), 64'd0);
    @(negedge clk);
    if4.in_valid = 1'b0;
    chk("hold second accepted", 64'(if4.busy), 64'd1);
    cyc = 0;
    while (!if4.out_valid && cyc < 20) begin
      @(negedge clk);
      cyc++;
    end
    e = ref4(32'h8000_0001, 32'h8000_0002, 1'b1);
    chk("hold second latency", 64'(cyc), 64'd4);
    chk("hold second sum", 64'(if4.sum), 64'(e[31:0]));
    chk("hold second cout", 64'(if4.cout), 64'(e[32]));
    @(negedge clk);
    if4.out_ready = 1'b0;
    chk("hold consumed", 64'(if4.out_valid), 64'd0);

    run4(32'h7FFF_FFFF, 32'h0000_0001, 1'b0, 0);
    run4(32'hFFFF_FFFF, 32'h0000_0001, 1'b0, 1);
    run4(32'h8000_0000, 32'h8000_0000, 1'b0, 0);
    run4(32'h00FF_00FF, 32'h0001_0001, 1'b1, 0);

    for (int i = 0; i < 20; i++) begin
      run4($urandom, $urandom, 1'($urandom_range(0, 1)), int'($urandom_range(0, 2)));
    end

    run1(8'hF0, 8'h20, 1'b0);
    run1(8'h7F, 8'h00, 1'b1);
    for (int i = 0; i < 8; i++) begin
      run1(8'($urandom), 8'($urandom), 1'($urandom_range(0, 1)));
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/wide_adder_seq.md
Name: wide_adder_seq

Overview:
- Multi-cycle wide adder that computes a WORDS×N-bit sum by passing one N-bit chunk per cycle through a single fa #(.N(N)) instance.
- Each chunk's cout is registered and fed back as the next chunk's cin.
- Sits directly around the chunk adder: it drives the adder's a/b/cin and consumes its sum/cout.
- Uses valid/ready handshakes on input and output; area-cheap alternative to a WORDS×N combinational adder.

Parameters:
- N, 8, chunk width in bits; width of the fa instance.
- WORDS, 4, number of chunks, ≥1; total operand width W = N*WORDS.

Ports:
- clk  input  1  rising-edge clock.
- rst_n  input  1  asynchronous active-low reset.
- in_valid  input  1  operands a, b and cin are valid.
- in_ready  output  1  block can accept operands.
- a  input  W  operand A.
- b  input  W  operand B.
- cin  input  1  carry into chunk 0.
- out_valid  output  1  sum/cout are valid.
- out_ready  input  1  consumer accepts the result.
- sum  output  W  registered result, a+b+cin mod 2^W.
- cout  output  1  carry out of the top chunk.
- busy  output  1  high in ADD or DONE.

Behaviour:
- Interface: one clock clk; reset rst_n is asynchronous and active-low.
- Reset (async assert, sync deassert handled upstream): state=IDLE; in_ready=1; out_valid=0; busy=0; sum=0; cout=0; internal carry=0; idx=0; operand registers=0.
- States: IDLE, ADD, DONE.
- IDLE:
  - in_ready=1.
  - On in_valid&&in_ready: latch a and b, carry<=cin, idx<=0, go to ADD.
  - Inputs are ignored when in_valid=0.
- ADD:
  - in_ready=0, busy=1.
  - Each cycle the fa sees a_reg chunk[idx], b_reg chunk[idx] and carry.
  - sum chunk[idx]<=fa.sum; carry<=fa.cout; idx<=idx+1.
  - When idx==WORDS-1: cout<=fa.cout, go to DONE.
- DONE:
  - out_valid=1; sum and cout held stable.
  - On out_ready: out_valid<=0, go to IDLE.
  - Holds indefinitely while out_ready=0.
- Latency: handshake accepted at edge k → out_valid high after edge k+WORDS. Throughput: one result per WORDS+2 cycles minimum.
- No overlap: in_ready=0 in the DONE cycle, so a new accept cannot coincide with output consumption.
- Arithmetic: unsigned, modulo 2^W. cout equals bit W of the full-precision sum. Chunk 0 is bits [N-1:0], little-endian order.
- WORDS=1: ADD lasts exactly one cycle; result equals a single fa pass.
- idx width is $clog2(WORDS) with a minimum of 1; idx never exceeds WORDS-1.
- sum register retains the previous result until overwritten chunk-by-chunk; value is only defined while out_valid=1.
- rst_n asserted mid-ADD or mid-DONE: immediate return to reset values; the partial result is discarded and no out_valid pulse occurs.
- out_ready while out_valid=0: ignored.
- in_valid held high through ADD/DONE: not accepted until the return to IDLE.

Optional Feature:
- Macro WIDE_ADDER_SEQ_OVF_EN.
- Defined:
  - Extra output ovf (1 bit), two's-complement signed overflow of the W-bit add.
  - ovf = carry into the MSB XOR carry out of the MSB, captured on the final ADD cycle.
  - Reset 0; valid with out_valid.
- Undefined: no ovf port; no extra logic.

Decomposition:
- Package wide_adder_seq_pkg:
  - typedef enum logic [1:0] state_t {IDLE, ADD, DONE}.
  - Helper function for idx width ($clog2 with minimum 1).
- Sub-module: existing fa #(.N(N)), instantiated once as the chunk datapath. No other sub-modules.

Test Plan (N=8, WORDS=4):
- a=32'hFFFF_FFFF, b=32'h0000_0001, cin=0, out_ready=1 → out_valid 4 cycles after accept; sum=32'h0000_0000, cout=1; in_ready back to 1 one cycle after the DONE handshake.
- a=32'h1234_5678, b=32'h1111_1111, cin=1; out_ready=0 for 5 cycles, then 1 → sum=32'h2345_678A, cout=0, held stable every cycle of the stall.
- Accept a=32'h0000_00FF, b=32'h0000_0001; assert rst_n=0 after 2 ADD cycles → all outputs reset immediately; out_valid never pulses; next transaction a=2, b=3 → sum=5.
- Separate build with WORDS=1, a=8'hF0, b=8'h20, cin=0 → sum=8'h10, cout=1, out_valid one cycle after accept.
- in_valid held high with new operands during ADD → not accepted; in_ready=0 throughout ADD/DONE; second operand set is consumed only after the return to IDLE.
- With WIDE_ADDER_SEQ_OVF_EN: a=32'h7FFF_FFFF, b=1 → sum=32'h8000_0000, cout=0, ovf=1. Then a=32'hFFFF_FFFF, b=1 → ovf=0, cout=1.
